// File: rtl/nabp_angle_sequencer.sv
// Responder for the angle request handshake: serves a configured sequence of
// projection angles (start, step, count) with modulo-ANGLE_LIMIT wrap.
module nabp_angle_sequencer #(
  parameter int ANGLE_WIDTH = 12,
  parameter int ANGLE_LIMIT = 2880,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_start,
  input  logic [ANGLE_WIDTH-1:0] cfg_angle_start,
  input  logic [ANGLE_WIDTH-1:0] cfg_angle_step,
  input  logic [COUNT_WIDTH-1:0] cfg_angle_count,
  input  logic                   fr_next_angle,
  output logic                   fr_next_angle_ack,
  output logic [ANGLE_WIDTH-1:0] fr_angle,
  output logic                   fr_has_next_angle,
  output logic                   sq_busy,
  output logic                   sq_done
);

  typedef enum logic [1:0] {IDLE, READY, ACK, WAIT_LOW} state_t;

  localparam logic [ANGLE_WIDTH:0] LIMIT_W = (ANGLE_WIDTH+1)'(ANGLE_LIMIT);

  state_t                 state_q, state_d;
  logic [ANGLE_WIDTH-1:0] next_val_q, next_val_d;
  logic [ANGLE_WIDTH-1:0] step_q, step_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
  logic                   ack_q, ack_d;
  logic                   has_next_q, has_next_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [ANGLE_WIDTH:0]   sum;
  logic [ANGLE_WIDTH:0]   start_w;
  logic [ANGLE_WIDTH:0]   step_w;

  // Single conditional subtraction: a reduced value may still exceed the
  // limit if the raw input is at least twice ANGLE_LIMIT.
  function automatic logic [ANGLE_WIDTH-1:0] reduce(input logic [ANGLE_WIDTH:0] x);
    logic [ANGLE_WIDTH:0] r;
    r = (x >= LIMIT_W) ? (x - LIMIT_W) : x;
    return r[ANGLE_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    next_val_d  = next_val_q;
    step_d      = step_q;
    remaining_d = remaining_q;
    angle_d     = angle_q;
    ack_d       = 1'b0;
    has_next_d  = has_next_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sum         = {1'b0, next_val_q} + {1'b0, step_q};
    start_w     = {1'b0, cfg_angle_start};
    step_w      = {1'b0, cfg_angle_step};

    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          next_val_d  = reduce(start_w);
          step_d      = reduce(step_w);
          remaining_d = cfg_angle_count;
          if (cfg_angle_count != '0) begin
            state_d    = READY;
            busy_d     = 1'b1;
            has_next_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READY: begin
        if (fr_next_angle) begin
          angle_d     = next_val_q;
          next_val_d  = reduce(sum);
          remaining_d = remaining_q - COUNT_WIDTH'(1);
          has_next_d  = (remaining_q != COUNT_WIDTH'(1));
          ack_d       = 1'b1;
          state_d     = ACK;
        end
      end
      ACK: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!fr_next_angle) begin
          if (remaining_q != '0) begin
            state_d = READY;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      next_val_q  <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      angle_q     <= '0;
      ack_q       <= 1'b0;
      has_next_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_val_q  <= next_val_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
      angle_q     <= angle_d;
      ack_q       <= ack_d;
      has_next_q  <= has_next_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign fr_next_angle_ack = ack_q;
  assign fr_angle          = angle_q;
  assign fr_has_next_angle = has_next_q;
  assign sq_busy           = busy_q;
  assign sq_done           = done_q;

endmodule

// File: tb/tb_nabp_angle_sequencer.sv
// Bench for nabp_angle_sequencer: directed scenarios plus randomized
// sequences checked against a closed-form angle model.
module tb_nabp_angle_sequencer;

  localparam int AW = 12;
  localparam int CW = 10;
  localparam int LIM = 2880;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start;
  logic [AW-1:0] cfg_angle_start;
  logic [AW-1:0] cfg_angle_step;
  logic [CW-1:0] cfg_angle_count;
  logic          fr_next_angle;
  logic          fr_next_angle_ack;
  logic [AW-1:0] fr_angle;
  logic          fr_has_next_angle;
  logic          sq_busy;
  logic          sq_done;

  int tests = 0;
  int fails = 0;

  nabp_angle_sequencer #(
    .ANGLE_WIDTH(AW),
    .ANGLE_LIMIT(LIM),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_start        (cfg_start),
    .cfg_angle_start  (cfg_angle_start),
    .cfg_angle_step   (cfg_angle_step),
    .cfg_angle_count  (cfg_angle_count),
    .fr_next_angle    (fr_next_angle),
    .fr_next_angle_ack(fr_next_angle_ack),
    .fr_angle         (fr_angle),
    .fr_has_next_angle(fr_has_next_angle),
    .sq_busy          (sq_busy),
    .sq_done          (sq_done)
  );

  always #5 clk = ~clk;

  // Angle i of a sequence: reduced start plus i reduced steps, modulo the limit.
  function automatic int model_angle(input int st, input int sp, input int i);
    int rs, rp;
    rs = (st >= LIM) ? st - LIM : st;
    rp = (sp >= LIM) ? sp - LIM : sp;
    return (rs + i * rp) % LIM;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int st, input int sp, input int cnt,
                          output logic busy_s, output logic has_s, output logic done_s);
    cfg_angle_start = AW'(st);
    cfg_angle_step  = AW'(sp);
    cfg_angle_count = CW'(cnt);
    cfg_start       = 1'b1;
    tick();
    cfg_start = 1'b0;
    busy_s = sq_busy;
    has_s  = fr_has_next_angle;
    done_s = sq_done;
  endtask

  // One request/ack transaction; hold = extra cycles the request stays high after ack.
  task automatic serve(input int hold, output logic got, output logic [AW-1:0] ang,
                       output logic has, output int extra_acks, output logic done_exit,
                       output logic done_after, output logic busy_after);
    got = 1'b0; ang = '0; has = 1'b0; extra_acks = 0;
    done_exit = 1'b0; done_after = 1'b0; busy_after = 1'b0;
    fr_next_angle = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (fr_next_angle_ack) begin
        got = 1'b1;
        ang = fr_angle;
        has = fr_has_next_angle;
      end
    end
    if (got) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        if (fr_next_angle_ack) extra_acks++;
      end
      fr_next_angle = 1'b0;
      for (int i = 0; i < ((hold == 0) ? 2 : 1); i++) begin
        tick();
        if (fr_next_angle_ack) extra_acks++;
      end
      done_exit  = sq_done;
      busy_after = sq_busy;
      tick();
      done_after = sq_done;
    end else begin
      fr_next_angle = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_start = 1'b0; fr_next_angle = 1'b0;
    cfg_angle_start = '0; cfg_angle_step = '0; cfg_angle_count = '0;
    tick(); tick();
    tests++;
    if ({fr_next_angle_ack, fr_angle, fr_has_next_angle, sq_busy, sq_done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ack=%b angle=%0d has=%b busy=%b done=%b, want all 0",
               fr_next_angle_ack, fr_angle, fr_has_next_angle, sq_busy, sq_done);
    end
    reset = 1'b0;
    tick();
  endtask

  // Runs a full sequence with the given hold per request and checks every transaction.
  task automatic run_sequence(input string name, input int st, input int sp, input int cnt,
                              input int hold);
    logic b, h, d, got, has, dx, da, ba;
    logic [AW-1:0] ang;
    int extra;
    do_start(st, sp, cnt, b, h, d);
    tests++;
    if (b !== 1'b1 || h !== 1'b1 || d !== 1'b0) begin
      fails++;
      $display("FAIL %s_start: got busy=%b has=%b done=%b, want 1 1 0", name, b, h, d);
    end
    for (int i = 0; i < cnt; i++) begin
      serve(hold, got, ang, has, extra, dx, da, ba);
      tests++;
      if (got !== 1'b1 || ang !== AW'(model_angle(st, sp, i)) || has !== (i != cnt - 1)) begin
        fails++;
        $display("FAIL %s_angle%0d: got ack=%b angle=%0d has=%b, want 1 %0d %b",
                 name, i, got, ang, has, model_angle(st, sp, i), (i != cnt - 1));
      end
      tests++;
      if (extra !== 0 || dx !== (i == cnt - 1) || da !== 1'b0 || ba !== (i != cnt - 1)) begin
        fails++;
        $display("FAIL %s_post%0d: got extra_acks=%0d done=%b done_next=%b busy=%b, want 0 %b 0 %b",
                 name, i, extra, dx, da, ba, (i == cnt - 1), (i != cnt - 1));
      end
    end
  endtask

  task automatic test_basic();
    run_sequence("basic", 0, 16, 4, 0);
  endtask

  task automatic test_wrap();
    run_sequence("wrap", 2864, 32, 3, 0);
    run_sequence("wrap_start", 2900, 1, 1, 0);
  endtask

  task automatic test_slow_consumer();
    run_sequence("slow", 10, 100, 3, 5);
  endtask

  task automatic test_count_zero();
    logic b, h, d, got, has, dx, da, ba;
    logic [AW-1:0] ang;
    int extra;
    do_start(50, 5, 0, b, h, d);
    tests++;
    if (b !== 1'b0 || h !== 1'b0 || d !== 1'b1) begin
      fails++;
      $display("FAIL count0_start: got busy=%b has=%b done=%b, want 0 0 1", b, h, d);
    end
    tick();
    tests++;
    if (sq_done !== 1'b0) begin
      fails++;
      $display("FAIL count0_done_pulse: got done=%b, want 0", sq_done);
    end
    serve(0, got, ang, has, extra, dx, da, ba);
    tests++;
    if (got !== 1'b0 || fr_has_next_angle !== 1'b0) begin
      fails++;
      $display("FAIL idle_request: got ack=%b has=%b, want 0 0", got, fr_has_next_angle);
    end
  endtask

  task automatic test_start_while_busy();
    logic b, h, d, got, has, dx, da, ba;
    logic [AW-1:0] ang;
    int extra;
    do_start(0, 16, 8, b, h, d);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        do_start(500, 100, 3, b, h, d);
        tests++;
        if (d !== 1'b0 || b !== 1'b1) begin
          fails++;
          $display("FAIL busy_restart: got busy=%b done=%b, want 1 0", b, d);
        end
      end
      serve(0, got, ang, has, extra, dx, da, ba);
      tests++;
      if (got !== 1'b1 || ang !== AW'(16 * i) || has !== (i != 7) || dx !== (i == 7)) begin
        fails++;
        $display("FAIL busy_angle%0d: got ack=%b angle=%0d has=%b done=%b, want 1 %0d %b %b",
                 i, got, ang, has, dx, 16 * i, (i != 7), (i == 7));
      end
    end
  endtask

  task automatic test_reset_midseq();
    logic b, h, d, got, has, dx, da, ba;
    logic [AW-1:0] ang;
    int extra;
    do_start(0, 16, 4, b, h, d);
    serve(0, got, ang, has, extra, dx, da, ba);
    fr_next_angle = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (fr_next_angle_ack) begin
        got = 1'b1;
        ang = fr_angle;
      end
    end
    tests++;
    if (got !== 1'b1 || ang !== AW'(16)) begin
      fails++;
      $display("FAIL rst_angle2: got ack=%b angle=%0d, want 1 16", got, ang);
    end
    fr_next_angle = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if ({fr_next_angle_ack, fr_angle, fr_has_next_angle, sq_busy, sq_done} !== '0) begin
      fails++;
      $display("FAIL rst_mid_outputs: got ack=%b angle=%0d has=%b busy=%b done=%b, want all 0",
               fr_next_angle_ack, fr_angle, fr_has_next_angle, sq_busy, sq_done);
    end
    tick();
    tests++;
    if (sq_done !== 1'b0 || sq_busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_nodone: got done=%b busy=%b, want 0 0", sq_done, sq_busy);
    end
    run_sequence("after_rst", 100, 1, 2, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int st, sp, cnt, hold;
      st   = int'($urandom_range(0, 4095));
      sp   = int'($urandom_range(0, 4095));
      cnt  = int'($urandom_range(1, 6));
      hold = int'($urandom_range(0, 3));
      run_sequence("rand", st, sp, cnt, hold);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_slow_consumer();
    test_count_zero();
    test_start_while_busy();
    test_reset_midseq();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
